// File: rtl/um_report_arb_pkg.sv
//------------------------------------------------------------------------------
// um_report_arb_pkg: beat header codes, beat width and arbiter state encoding.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package um_report_arb_pkg;

    localparam int DATA_W = 134;

    localparam logic [1:0] HDR_HEAD = 2'b01;
    localparam logic [1:0] HDR_BODY = 2'b11;
    localparam logic [1:0] HDR_TAIL = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_GRANT = 3'b010,
        ST_XFER  = 3'b100
    } state_t;

    function automatic logic [1:0] hdr_of(input logic [DATA_W-1:0] beat);
        return beat[DATA_W-1 -: 2];
    endfunction

endpackage

`default_nettype wire

// File: rtl/um_report_arb_rr_pick2.sv
//------------------------------------------------------------------------------
// um_report_arb_rr_pick2: combinational two-way round-robin picker.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module um_report_arb_rr_pick2 (
    input  logic [1:0] i_req,
    input  logic       i_rr_last,
    output logic       o_idx,
    output logic       o_valid
);

    // On a tie the port that was not served last wins.
    always_comb begin
        o_valid = |i_req;
        if (&i_req) begin
            o_idx = ~i_rr_last;
        end else begin
            o_idx = i_req[1];
        end
    end

endmodule

`default_nettype wire

// File: rtl/um_report_arb.sv
//------------------------------------------------------------------------------
// um_report_arb: packet-atomic two-port arbiter with round-robin and grant timeout.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module um_report_arb
    import um_report_arb_pkg::*;
#(
    parameter int GRANT_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_a_req,
    input  logic              i_b_req,
    output logic              o_a_ready,
    output logic              o_b_ready,
    input  logic              i_a_data_wr,
    input  logic [DATA_W-1:0] i_a_data,
    input  logic              i_a_data_valid,
    input  logic              i_a_data_valid_wr,
    input  logic              i_b_data_wr,
    input  logic [DATA_W-1:0] i_b_data,
    input  logic              i_b_data_valid,
    input  logic              i_b_data_valid_wr,
    output logic              o_data_wr,
    output logic [DATA_W-1:0] o_data,
    output logic              o_data_valid,
    output logic              o_data_valid_wr,
    output logic [31:0]       o_drop_cnt,
    output logic [15:0]       o_timeout_cnt
);

    localparam logic [15:0] C_TMO_LAST = 16'(GRANT_TIMEOUT - 1);

    state_t            r_state;
    logic              r_owner;
    logic              r_rr_last;
    logic [15:0]       r_timer;
    logic              r_a_ready;
    logic              r_b_ready;
    logic              r_out_wr;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_out_valid_wr;
    logic [31:0]       r_drop_cnt;
    logic [15:0]       r_timeout_cnt;

    logic              w_pick_idx;
    logic              w_pick_valid;
    logic              w_own_req;
    logic              w_own_wr;
    logic [DATA_W-1:0] w_own_data;
    logic              w_own_valid;
    logic              w_own_valid_wr;
    logic [1:0]        w_own_hdr;
    logic              w_head;
    logic              w_tail;
    logic              w_fwd;
    logic              w_drop_a;
    logic              w_drop_b;

    um_report_arb_rr_pick2 u_pick (
        .i_req     ({i_b_req, i_a_req}),
        .i_rr_last (r_rr_last),
        .o_idx     (w_pick_idx),
        .o_valid   (w_pick_valid)
    );

    assign w_own_req      = r_owner ? i_b_req           : i_a_req;
    assign w_own_wr       = r_owner ? i_b_data_wr       : i_a_data_wr;
    assign w_own_data     = r_owner ? i_b_data          : i_a_data;
    assign w_own_valid    = r_owner ? i_b_data_valid    : i_a_data_valid;
    assign w_own_valid_wr = r_owner ? i_b_data_valid_wr : i_a_data_valid_wr;
    assign w_own_hdr      = hdr_of(w_own_data);

    assign w_head = (r_state == ST_GRANT) & w_own_wr & (w_own_hdr == HDR_HEAD);
    assign w_tail = (r_state == ST_XFER)  & w_own_wr & (w_own_hdr == HDR_TAIL);
    assign w_fwd  = w_head | (r_state == ST_XFER);

    // Any written beat that is not forwarded is a drop, whichever port sent it.
    assign w_drop_a = i_a_data_wr & ~(w_fwd & ~r_owner);
    assign w_drop_b = i_b_data_wr & ~(w_fwd &  r_owner);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_owner        <= 1'b0;
            r_rr_last      <= 1'b1;
            r_timer        <= '0;
            r_a_ready      <= 1'b0;
            r_b_ready      <= 1'b0;
            r_out_wr       <= 1'b0;
            r_out_data     <= '0;
            r_out_valid    <= 1'b0;
            r_out_valid_wr <= 1'b0;
            r_drop_cnt     <= '0;
            r_timeout_cnt  <= '0;
        end else begin
            r_drop_cnt     <= r_drop_cnt + 32'(w_drop_a) + 32'(w_drop_b);
            r_out_wr       <= w_fwd & w_own_wr;
            r_out_data     <= w_fwd ? w_own_data : '0;
            r_out_valid    <= w_fwd & w_own_valid;
            r_out_valid_wr <= w_fwd & w_own_valid_wr;

            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_owner   <= w_pick_idx;
                        r_a_ready <= ~w_pick_idx;
                        r_b_ready <= w_pick_idx;
                        r_timer   <= '0;
                        r_state   <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (w_head) begin
                        r_a_ready <= 1'b0;
                        r_b_ready <= 1'b0;
                        r_state   <= ST_XFER;
                    end else if (!w_own_req) begin
                        r_a_ready <= 1'b0;
                        r_b_ready <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else if (r_timer == C_TMO_LAST) begin
                        r_a_ready <= 1'b0;
                        r_b_ready <= 1'b0;
                        r_rr_last <= r_owner;
                        if (r_timeout_cnt != 16'hFFFF) begin
                            r_timeout_cnt <= r_timeout_cnt + 16'd1;
                        end
                        r_state   <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                ST_XFER: begin
                    if (w_tail) begin
                        r_rr_last <= r_owner;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_a_ready <= 1'b0;
                    r_b_ready <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_a_ready       = r_a_ready;
    assign o_b_ready       = r_b_ready;
    assign o_data_wr       = r_out_wr;
    assign o_data          = r_out_data;
    assign o_data_valid    = r_out_valid;
    assign o_data_valid_wr = r_out_valid_wr;
    assign o_drop_cnt      = r_drop_cnt;
    assign o_timeout_cnt   = r_timeout_cnt;

endmodule

`default_nettype wire

// File: tb/tb_um_report_arb.sv
//------------------------------------------------------------------------------
// tb_um_report_arb: directed bench with a packet-level reference model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_um_report_arb;

    localparam int DW  = 134;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_req = 0, b_req = 0;
    logic          a_wr = 0, a_v = 0, a_vwr = 0;
    logic          b_wr = 0, b_v = 0, b_vwr = 0;
    logic [DW-1:0] a_data = '0, b_data = '0;

    logic          o_a_ready, o_b_ready;
    logic          o_data_wr, o_data_valid, o_data_valid_wr;
    logic [DW-1:0] o_data;
    logic [31:0]   o_drop_cnt;
    logic [15:0]   o_timeout_cnt;

    int checks = 0;
    int failures = 0;

    um_report_arb #(.GRANT_TIMEOUT(TMO)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_a_req           (a_req),
        .i_b_req           (b_req),
        .o_a_ready         (o_a_ready),
        .o_b_ready         (o_b_ready),
        .i_a_data_wr       (a_wr),
        .i_a_data          (a_data),
        .i_a_data_valid    (a_v),
        .i_a_data_valid_wr (a_vwr),
        .i_b_data_wr       (b_wr),
        .i_b_data          (b_data),
        .i_b_data_valid    (b_v),
        .i_b_data_valid_wr (b_vwr),
        .o_data_wr         (o_data_wr),
        .o_data            (o_data),
        .o_data_valid      (o_data_valid),
        .o_data_valid_wr   (o_data_valid_wr),
        .o_drop_cnt        (o_drop_cnt),
        .o_timeout_cnt     (o_timeout_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model: packet-level arbitration rules ----------------
    int            m_owner;      // -1 none, 0 = A, 1 = B
    bit            m_waiting;    // granted, head not yet seen
    int            m_timer;
    int            m_rr_last;
    int            m_wr[2], m_req[2], m_v[2], m_vwr[2];
    logic [DW-1:0] m_d[2];
    logic [1:0]    m_hdr;
    int            m_pick, m_nd, m_o;
    logic          exp_ra, exp_rb, exp_wr, exp_v, exp_vwr;
    logic [DW-1:0] exp_data;
    logic [31:0]   exp_drop;
    logic [15:0]   exp_tout;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1; m_waiting = 0; m_timer = 0; m_rr_last = 1;
            exp_ra = 0; exp_rb = 0; exp_wr = 0; exp_v = 0; exp_vwr = 0;
            exp_data = '0; exp_drop = '0; exp_tout = '0;
        end else begin
            m_wr[0] = a_wr; m_d[0] = a_data; m_v[0] = a_v; m_vwr[0] = a_vwr; m_req[0] = a_req;
            m_wr[1] = b_wr; m_d[1] = b_data; m_v[1] = b_v; m_vwr[1] = b_vwr; m_req[1] = b_req;
            exp_wr = 0; exp_data = '0; exp_v = 0; exp_vwr = 0;
            m_nd = 0;
            for (int p = 0; p < 2; p++) if (m_wr[p] != 0 && p != m_owner) m_nd++;
            if (m_owner < 0) begin
                if (m_req[0] != 0 && m_req[1] != 0) m_pick = (m_rr_last == 1) ? 0 : 1;
                else if (m_req[0] != 0)             m_pick = 0;
                else if (m_req[1] != 0)             m_pick = 1;
                else                                m_pick = -1;
                if (m_pick >= 0) begin
                    m_owner = m_pick; m_waiting = 1; m_timer = 0;
                end
            end else begin
                m_o   = m_owner;
                m_hdr = m_d[m_o][DW-1 -: 2];
                if (m_waiting && !(m_wr[m_o] != 0 && m_hdr == 2'b01)) begin
                    if (m_wr[m_o] != 0) m_nd++;
                    if (m_req[m_o] == 0) begin
                        m_owner = -1; m_waiting = 0;
                    end else if (m_timer == TMO - 1) begin
                        if (exp_tout != 16'hFFFF) exp_tout = exp_tout + 16'd1;
                        m_rr_last = m_o; m_owner = -1; m_waiting = 0;
                    end else begin
                        m_timer++;
                    end
                end else begin
                    exp_wr = m_wr[m_o][0]; exp_data = m_d[m_o];
                    exp_v = m_v[m_o][0]; exp_vwr = m_vwr[m_o][0];
                    if (!m_waiting && m_wr[m_o] != 0 && m_hdr == 2'b10) begin
                        m_rr_last = m_o; m_owner = -1;
                    end
                    m_waiting = 0;
                end
            end
            exp_drop = exp_drop + 32'(m_nd);
            exp_ra = (m_owner == 0) && m_waiting;
            exp_rb = (m_owner == 1) && m_waiting;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("ready_a", DW'(o_a_ready), DW'(exp_ra));
            check("ready_b", DW'(o_b_ready), DW'(exp_rb));
            check("out_ctl", DW'({o_data_wr, o_data_valid, o_data_valid_wr}), DW'({exp_wr, exp_v, exp_vwr}));
            check("out_data", o_data, exp_data);
            check("drop_cnt", DW'(o_drop_cnt), DW'(exp_drop));
            check("timeout_cnt", DW'(o_timeout_cnt), DW'(exp_tout));
            if (o_a_ready && o_b_ready) check("one_ready", 2, 1);
        end
    end

    // ---------------- monitors for hand-computed checks ----------------
    int grant_q[$];
    int n_beats = 0;
    int rb_run = 0, last_rb_run = 0;

    always @(posedge o_a_ready) grant_q.push_back(0);
    always @(posedge o_b_ready) grant_q.push_back(1);
    always @(negedge clk) begin
        if (o_data_wr) n_beats++;
        if (o_b_ready) rb_run++;
        else if (rb_run > 0) begin last_rb_run = rb_run; rb_run = 0; end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_beat(input int p, input bit wr, input logic [1:0] hdr, input logic [23:0] tag, input bit v);
        logic [DW-1:0] d;
        d = wr ? {hdr, 108'd0, tag} : '0;
        if (p == 0) begin a_wr = wr; a_data = d; a_v = v; a_vwr = v; end
        else        begin b_wr = wr; b_data = d; b_v = v; b_vwr = v; end
    endtask

    task automatic set_req(input int p, input bit r);
        if (p == 0) a_req = r; else b_req = r;
    endtask

    task automatic send_pkt(input int p, input int n, input logic [23:0] tag, output int lat);
        bit ok;
        logic [1:0] hdr;
        ok = 0; lat = 0;
        set_req(p, 1);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            lat++;
            if ((p == 0) ? o_a_ready : o_b_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            check("ready_wait_expired", 0, 1);
            set_req(p, 0);
            return;
        end
        for (int k = 0; k < n; k++) begin
            hdr = (k == 0) ? 2'b01 : ((k == n - 1) ? 2'b10 : 2'b11);
            set_beat(p, 1, hdr, tag + 24'(k), k == n - 1);
            @(negedge clk);
            if (k == 0) set_req(p, 0);
        end
        set_beat(p, 0, 2'b00, 24'd0, 0);
    endtask

    task automatic do_reset();
        rst_n = 0;
        a_req = 0; b_req = 0;
        set_beat(0, 0, 2'b00, 24'd0, 0);
        set_beat(1, 0, 2'b00, 24'd0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        grant_q.delete();
        n_beats = 0; rb_run = 0; last_rb_run = 0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int lat;
    int exp_order[6] = '{0, 1, 0, 1, 0, 1};

    initial begin
        // reset state
        rst_n = 0;
        repeat (2) @(negedge clk);
        check("rst_ready", DW'({o_a_ready, o_b_ready}), DW'(0));
        check("rst_ctl", DW'({o_data_wr, o_data_valid, o_data_valid_wr}), DW'(0));
        check("rst_data", o_data, '0);
        check("rst_drop", DW'(o_drop_cnt), DW'(0));
        check("rst_tout", DW'(o_timeout_cnt), DW'(0));
        do_reset();

        // single port A, 4-beat packet
        send_pkt(0, 4, 24'hA00000, lat);
        repeat (3) @(negedge clk);
        check("a_ready_latency", DW'(lat), DW'(1));
        check("a_beats", DW'(n_beats), DW'(4));
        check("a_drop", DW'(o_drop_cnt), DW'(0));
        // both ports write in IDLE: two drops in one cycle
        set_beat(0, 1, 2'b11, 24'h1, 0);
        set_beat(1, 1, 2'b11, 24'h2, 0);
        @(negedge clk);
        set_beat(0, 0, 2'b00, 24'd0, 0);
        set_beat(1, 0, 2'b00, 24'd0, 0);
        @(negedge clk);
        check("idle_double_drop", DW'(o_drop_cnt), DW'(2));

        // tie and alternation over six packets
        do_reset();
        fork
            begin
                int l0;
                for (int i = 0; i < 3; i++) send_pkt(0, 3, 24'hA10000 + 24'(i * 16), l0);
            end
            begin
                int l1;
                for (int i = 0; i < 3; i++) send_pkt(1, 2, 24'hB10000 + 24'(i * 16), l1);
            end
        join
        repeat (3) @(negedge clk);
        check("tie_grants", DW'(grant_q.size()), DW'(6));
        for (int i = 0; i < 6 && i < grant_q.size(); i++) check("tie_order", DW'(grant_q[i]), DW'(exp_order[i]));
        check("tie_beats", DW'(n_beats), DW'(15));

        // timeout on stalled B, pending A granted next
        do_reset();
        set_req(1, 1);
        repeat (3) @(negedge clk);
        send_pkt(0, 3, 24'hA20000, lat);
        check("tmo_run_len", DW'(last_rb_run), DW'(16));
        check("tmo_cnt", DW'(o_timeout_cnt), DW'(1));
        check("tmo_first_b", DW'(grant_q[0]), DW'(1));
        check("tmo_then_a", DW'(grant_q[1]), DW'(0));
        set_req(1, 0);
        repeat (4) @(negedge clk);

        // intrusion: B writes three beats while A is mid-packet
        do_reset();
        fork
            send_pkt(0, 6, 24'hA30000, lat);
            begin
                repeat (3) @(negedge clk);
                for (int i = 0; i < 3; i++) begin
                    set_beat(1, 1, 2'b01, 24'hB30000 + 24'(i), 1);
                    @(negedge clk);
                end
                set_beat(1, 0, 2'b00, 24'd0, 0);
            end
        join
        repeat (2) @(negedge clk);
        check("intr_drop", DW'(o_drop_cnt), DW'(3));
        check("intr_beats", DW'(n_beats), DW'(6));

        // reset in the middle of a packet
        do_reset();
        set_req(0, 1);
        @(negedge clk);
        @(negedge clk);
        set_beat(0, 1, 2'b01, 24'hA40000, 0);
        @(negedge clk);
        set_req(0, 0);
        set_beat(0, 1, 2'b11, 24'hA40001, 0);
        @(negedge clk);
        rst_n = 0;
        #1;
        check("midrst_ctl", DW'({o_data_wr, o_data_valid, o_data_valid_wr, o_a_ready, o_b_ready}), DW'(0));
        check("midrst_data", o_data, '0);
        do_reset();
        send_pkt(0, 3, 24'hA50000, lat);
        repeat (2) @(negedge clk);
        check("postrst_beats", DW'(n_beats), DW'(3));
        check("postrst_cnts", DW'({o_drop_cnt, o_timeout_cnt}), DW'(0));

        // timeout counter saturation from a preloaded value
        @(posedge clk);
        #1;
        force dut.r_timeout_cnt = 16'hFFFD;
        exp_tout = 16'hFFFD;
        @(posedge clk);
        #1;
        release dut.r_timeout_cnt;
        set_req(1, 1);
        repeat (3 * (TMO + 1) + 2) @(negedge clk);
        set_req(1, 0);
        repeat (3) @(negedge clk);
        check("tmo_saturate", DW'(o_timeout_cnt), DW'(16'hFFFF));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
